// File: rtl/datapath_resp.sv
// rtl/datapath_resp.sv - ALU plus 32-word data memory returning one registered result
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   operand1          ALU operand A / memory base address
//   operand2          ALU operand B / store data
//   offset            address offset / ALU immediate
//   opcode            ALU operation select (4'b1111 = hold)
//   sel1              result2 source: 1 = ALU register, 0 = memory read register
//   sel3              address source: 1 = operand1+offset, 0 = operand1
//   w_r               memory write enable (ignored while clearing)
//   result2           sel1 ? alu_q : mem_q
//   zero, carry       registered ALU flags
//   busy              high while the memory clear sequence runs
module datapath_resp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    input  logic [DATA_WIDTH-1:0] offset,
    input  logic [3:0]            opcode,
    input  logic                  sel1,
    input  logic                  sel3,
    input  logic                  w_r,
    output logic [DATA_WIDTH-1:0] result2,
    output logic                  zero,
    output logic                  carry,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [ADDR_BITS-1:0]  CNT_ONE  = 1;
    localparam logic [DATA_WIDTH:0]   WIDE_ONE = 1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_BITS-1:0]  clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0] alu_q, alu_d;
    logic [DATA_WIDTH-1:0] mem_q, mem_d;
    logic                  zero_q, zero_d;
    logic                  carry_q, carry_d;

    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic                  ram_we;
    logic [ADDR_BITS-1:0]  ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    logic [DATA_WIDTH-1:0]   eff_sum;
    logic [ADDR_BITS-1:0]    eff_addr;
    logic [DATA_WIDTH:0]     wide;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0]   res;
    logic                    cy;
    logic                    unused_ok;

    // Address arithmetic wraps inside the memory: only the low bits are kept.
    assign eff_sum  = operand1 + offset;
    assign eff_addr = sel3 ? eff_sum[ADDR_BITS-1:0] : operand1[ADDR_BITS-1:0];
    assign prod     = operand1 * operand2;
    assign unused_ok = ^{eff_sum[DATA_WIDTH-1:ADDR_BITS], prod[2*DATA_WIDTH-1:DATA_WIDTH]};

    always_comb begin
        wide = '0;
        res  = '0;
        cy   = 1'b0;
        case (opcode)
            4'b0000: begin wide = {1'b0, operand1} + {1'b0, operand2}; res = wide[DATA_WIDTH-1:0]; cy = wide[DATA_WIDTH]; end
            // Top bit of the widened difference is the borrow.
            4'b0001: begin wide = {1'b0, operand1} - {1'b0, operand2}; res = wide[DATA_WIDTH-1:0]; cy = wide[DATA_WIDTH]; end
            4'b0010: res = operand1 & operand2;
            4'b0011: res = operand1 | operand2;
            4'b0100: res = operand1 ^ operand2;
            4'b0101: res = ~operand1;
            4'b0110: res = operand1 << operand2[2:0];
            4'b0111: res = operand1 >> operand2[2:0];
            4'b1000: begin wide = {1'b0, operand1} + WIDE_ONE; res = wide[DATA_WIDTH-1:0]; cy = wide[DATA_WIDTH]; end
            4'b1001: begin wide = {1'b0, operand1} - WIDE_ONE; res = wide[DATA_WIDTH-1:0]; cy = wide[DATA_WIDTH]; end
            4'b1010: res = operand1;
            4'b1011: res = operand2;
            4'b1100: begin wide = {1'b0, operand1} + {1'b0, offset}; res = wide[DATA_WIDTH-1:0]; cy = wide[DATA_WIDTH]; end
            4'b1101: res = {{(DATA_WIDTH-1){1'b0}}, (operand1 < operand2)};
            4'b1110: res = prod[DATA_WIDTH-1:0];
            default: res = '0;
        endcase
    end

    always_comb begin
        alu_d   = alu_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        if (opcode != 4'b1111) begin
            alu_d   = res;
            zero_d  = (res == '0);
            carry_d = cy;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_d     = mem_q;
        ram_we    = 1'b0;
        ram_waddr = eff_addr;
        ram_wdata = operand2;
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt_q;
            ram_wdata = '0;
            clr_cnt_d = clr_cnt_q + CNT_ONE;
            if (clr_cnt_q == '1) begin
                state_d = ST_RUN;
            end
        end else begin
            // Read-first: the read sees the array before this edge's write.
            mem_d  = ram[eff_addr];
            ram_we = w_r;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            alu_q     <= '0;
            mem_q     <= '0;
            zero_q    <= 1'b1;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            alu_q     <= alu_d;
            mem_q     <= mem_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
        end
    end

    // The array has no reset; the clear sequence zeroes it. Reset blocks any write.
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    assign result2 = sel1 ? alu_q : mem_q;
    assign zero    = zero_q;
    assign carry   = carry_q;
    assign busy    = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_datapath_resp.sv
// tb/tb_datapath_resp.sv - self-checking bench for datapath_resp
module tb_datapath_resp;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] operand1, operand2, offset;
    logic [3:0] opcode;
    logic       sel1, sel3, w_r;
    logic [7:0] result2;
    logic       zero, carry, busy;

    int  checks = 0;
    int  errors = 0;
    bit  started = 1'b0;

    datapath_resp #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
        .clk(clk), .rst(rst),
        .operand1(operand1), .operand2(operand2), .offset(offset),
        .opcode(opcode), .sel1(sel1), .sel3(sel3), .w_r(w_r),
        .result2(result2), .zero(zero), .carry(carry), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic over the operation table.
    int m_alu, m_memq, clear_left;
    int m_mem [32];
    bit m_zero, m_carry;

    function automatic void alu_ref(input int op, input int a, input int b, input int o,
                                    output int r, output bit c);
        c = 1'b0;
        case (op)
            0:  begin r = (a + b) % 256; c = (a + b) > 255; end
            1:  begin r = (a - b + 256) % 256; c = (a < b); end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = 255 - a;
            6:  r = (a << (b % 8)) % 256;
            7:  r = a >> (b % 8);
            8:  begin r = (a + 1) % 256; c = (a == 255); end
            9:  begin r = (a + 255) % 256; c = (a == 0); end
            10: r = a;
            11: r = b;
            12: begin r = (a + o) % 256; c = (a + o) > 255; end
            13: r = (a < b) ? 1 : 0;
            default: r = (a * b) % 256;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        int a, b, o, ea, r;
        bit c;
        if (rst) begin
            m_alu = 0; m_memq = 0; m_zero = 1'b1; m_carry = 1'b0; clear_left = 32;
        end else begin
            a = operand1; b = operand2; o = offset;
            if (clear_left > 0) begin
                m_mem[32 - clear_left] = 0;
                clear_left--;
            end else begin
                ea = (sel3 ? a + o : a) % 32;
                m_memq = m_mem[ea];
                if (w_r) m_mem[ea] = b;
            end
            if (opcode != 4'hF) begin
                alu_ref(int'(opcode), a, b, o, r, c);
                m_alu = r; m_carry = c; m_zero = (r == 0);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("model_result2", int'(result2), sel1 ? m_alu : m_memq);
            chk("model_zero", int'(zero), int'(m_zero));
            chk("model_carry", int'(carry), int'(m_carry));
            chk("model_busy", int'(busy), (clear_left > 0) ? 1 : 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_vec(input int op, input int a, input int b, input int o,
                           input int er, input int ec);
        opcode = op[3:0]; operand1 = a[7:0]; operand2 = b[7:0]; offset = o[7:0];
        sel1 = 1'b1; w_r = 1'b0;
        tick();
        chk($sformatf("op%0d_result", op), int'(result2), er);
        chk($sformatf("op%0d_carry", op), int'(carry), ec);
        chk($sformatf("op%0d_zero", op), int'(zero), (er == 0) ? 1 : 0);
    endtask

    task automatic count_busy(input string name, input bit wr);
        int cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) cnt++;
            w_r = wr;
            operand1 = i[7:0];
            operand2 = busy ? 8'hFF : 8'h00;
            tick();
        end
        chk(name, cnt, 32);
        w_r = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        operand1 = '0; operand2 = '0; offset = '0; opcode = 4'h0;
        sel1 = 1'b1; sel3 = 1'b0; w_r = 1'b0;
        #1 rst = 1'b1;
        started = 1'b1;
        repeat (2) tick();
        chk("reset_result2", int'(result2), 0);
        chk("reset_zero", int'(zero), 1);
        chk("reset_carry", int'(carry), 0);
        chk("reset_busy", int'(busy), 1);

        // Clear sequence with w_r held high; nonzero data offered while clearing.
        rst = 1'b0;
        opcode = 4'hA;
        chk("release_result2", int'(result2), 0);
        count_busy("busy_cycles", 1'b1);
        sel1 = 1'b0; sel3 = 1'b0;
        for (int a = 0; a < 32; a++) begin
            operand1 = a[7:0];
            tick();
            chk($sformatf("clear_word%0d", a), int'(result2), 0);
        end

        run_vec(0, 200, 100, 0, 44, 1);
        run_vec(1, 3, 5, 0, 254, 1);
        run_vec(2, 8'hF0, 8'h3C, 0, 8'h30, 0);
        run_vec(3, 8'hF0, 8'h0F, 0, 8'hFF, 0);
        run_vec(4, 8'hFF, 8'h0F, 0, 8'hF0, 0);
        run_vec(5, 8'h5A, 0, 0, 8'hA5, 0);
        run_vec(6, 8'h81, 3, 0, 8'h08, 0);
        run_vec(7, 8'h81, 8'h0B, 0, 8'h10, 0);
        run_vec(8, 255, 0, 0, 0, 1);
        run_vec(9, 0, 0, 0, 255, 1);
        run_vec(10, 8'h37, 0, 0, 8'h37, 0);
        run_vec(11, 0, 8'h99, 0, 8'h99, 0);
        run_vec(12, 250, 0, 10, 4, 1);
        run_vec(13, 3, 5, 0, 1, 0);
        run_vec(13, 5, 3, 0, 0, 0);
        run_vec(14, 16, 17, 0, 16, 0);

        // NOP holds a zero result.
        run_vec(1, 5, 5, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            opcode = 4'hF; operand1 = 8'd200; operand2 = 8'd100;
            tick();
            chk("nop_result2", int'(result2), 0);
            chk("nop_zero", int'(zero), 1);
            chk("nop_carry", int'(carry), 0);
        end
        opcode = 4'hA;

        // Wrapped address: 30+5 -> 3.
        w_r = 1'b1; sel3 = 1'b1; operand1 = 8'd30; offset = 8'd5; operand2 = 8'hA5;
        tick();
        w_r = 1'b0; sel1 = 1'b0; sel3 = 1'b0; operand1 = 8'd3;
        tick();
        chk("readback_addr3", int'(result2), 8'hA5);

        // Read-first on a same-address write.
        w_r = 1'b1; operand1 = 8'd7; operand2 = 8'h11;
        tick();
        operand2 = 8'h22;
        tick();
        chk("rfw_old", int'(result2), 8'h11);
        w_r = 1'b0;
        tick();
        chk("rfw_new", int'(result2), 8'h22);

        // Reset in RUN restarts the full clear and wipes address 3.
        rst = 1'b1;
        tick();
        chk("rst_run_busy", int'(busy), 1);
        chk("rst_run_result2", int'(result2), 0);
        rst = 1'b0;
        count_busy("busy_cycles_after_rst", 1'b0);
        sel1 = 1'b0; sel3 = 1'b0; operand1 = 8'd3;
        tick();
        chk("addr3_cleared", int'(result2), 0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_resp.md
DATAPATH_RESP -- requirements
Module: datapath_resp

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the data width of operands, offset, result and memory words.
REQ-003 Parameter ADDR_BITS, default 5, SHALL set the address width of the internal data memory (32 words).
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- operand1  in  DATA_WIDTH  ALU operand A; memory base address.
- operand2  in  DATA_WIDTH  ALU operand B; store data.
- offset  in  DATA_WIDTH  address offset; ALU immediate.
- opcode  in  4  ALU operation select.
- sel1  in  1  result2 source: 1 = ALU register, 0 = memory read register.
- sel3  in  1  address source: 1 = operand1+offset, 0 = operand1.
- w_r  in  1  memory write enable.
- result2  out  DATA_WIDTH  result returned to the control unit.
- zero  out  1  registered ALU result == 0.
- carry  out  1  registered ALU carry or borrow.
- busy  out  1  high while the memory clear sequence runs.

Function
REQ-005 FSM states SHALL be CLEAR and RUN; reset forces CLEAR.
REQ-006 In CLEAR, a 5-bit clear counter SHALL write 0 to address counter on each edge, stepping 0 to 31, and SHALL enter RUN on the edge that writes address 31 (32 cycles).
REQ-007 busy SHALL be 1 in CLEAR and 0 in RUN; the w_r input SHALL be ignored in CLEAR.
REQ-008 Effective address SHALL be (sel3 ? operand1+offset : operand1) truncated to the low ADDR_BITS bits, so carries wrap modulo 32.
REQ-009 In RUN, when w_r=1 at a rising edge, the block SHALL write operand2 to the effective address.
REQ-010 Every edge in RUN SHALL register mem[effective address] into mem_q (1-cycle read latency).
REQ-011 A read of the address being written in the same cycle SHALL return the old data (read-first).
REQ-012 Every edge (CLEAR or RUN) SHALL register the ALU result into alu_q, with zero and carry updated alongside, except for opcode 1111.
REQ-013 Opcodes (results modulo 2^DATA_WIDTH):
- 0000 A+B, carry = bit 8.
- 0001 A-B, carry = borrow.
- 0010 A&B.
- 0011 A|B.
- 0100 A^B.
- 0101 ~A.
- 0110 A<<B[2:0].
- 0111 A>>B[2:0] (logical).
- 1000 A+1.
- 1001 A-1.
- 1010 A.
- 1011 B.
- 1100 A+offset.
- 1101 (A<B unsigned) ? 1 : 0.
- 1110 low byte of A*B.
- 1111 NOP: alu_q, zero and carry hold their values.
REQ-014 carry SHALL be 0 for all opcodes except 0000, 0001, 1000, 1001 and 1100.
REQ-015 result2 SHALL be combinational: sel1 ? alu_q : mem_q.
REQ-016 Latency SHALL be: inputs present before edge k give an ALU or load result on result2 after edge k, valid for sampling at edge k+1.
REQ-017 This latency SHALL fit std_op (operands at DECODE, sampled at WRITE_BACK) and loadR (sampled at WRITE_BACK, two edges later).

Reset
REQ-018 Reset SHALL force the following, asynchronously: alu_q=0, mem_q=0, zero=1, carry=0, clear counter=0, state=CLEAR, busy=1.
REQ-019 result2 SHALL therefore read 0 during and immediately after reset.
REQ-020 Reset asserted mid-CLEAR or mid-RUN SHALL abort any write in progress and restart the full 32-word clear after release.

Verification
REQ-021 Reset, then release; apply w_r=1 for 40 cycles -> busy=1 for exactly 32 cycles, then 0; no writes occur during CLEAR; all 32 words read 0.
REQ-022 RUN, opcode=0000, operand1=200, operand2=100, sel1=1 -> result2=44, carry=1, zero=0 one edge later.
REQ-023 opcode=0001, operand1=5, operand2=5 -> result2=0, zero=1, carry=0; then opcode=1111 for 3 cycles -> result2, zero and carry hold.
REQ-024 Write: w_r=1, sel3=1, operand1=30, offset=5, operand2=8'hA5 -> address 3 written. Read back: w_r=0, sel1=0, operand1=3, sel3=0 -> result2=8'hA5 one edge later.
REQ-025 Same-address read and write: w_r=1, address 7, old value 8'h11, new value 8'h22 -> mem_q=8'h11 that edge, 8'h22 the next edge.
REQ-026 Assert rst during RUN after address 3 has been written -> after release, busy=1 for 32 cycles and address 3 reads 0.
